// File: rtl/mc_datapath_gen_if.sv
// Memory bus between the multicycle datapath (master) and unified memory (slave):
// request held stable until a single-cycle acknowledge.
interface mc_datapath_gen_if #(
    parameter int ADDR_W = 16
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mc_datapath_gen.sv
// Multicycle MIPS datapath: PC/IR/MDR/A/B/ALUOut, 32x32 register file and a
// stalling memory handshake. Define DP_EPC_EN to add exception PC capture.
module mc_datapath_gen #(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC  = 'h80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCWrite,
    input  logic              PCWriteCond,
    input  logic              BranchNe,
    input  logic [1:0]        PCSource,
    input  logic              IorD,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IRWrite,
    input  logic              RegWrite,
    input  logic [1:0]        RegDst,
    input  logic [1:0]        MemToReg,
    input  logic [1:0]        ALUSrcA,
    input  logic [1:0]        ALUSrcB,
    input  logic              zero,
    input  logic [31:0]       aluResult,
`ifdef DP_EPC_EN
    input  logic              ExcTake,
    output logic [ADDR_W-1:0] epc,
`endif
    output logic [5:0]        op,
    output logic [5:0]        funct,
    output logic [31:0]       aluParamData1,
    output logic [31:0]       aluParamData2,
    output logic              stall,
    mc_datapath_gen_if.master mem
);

    typedef enum logic {IDLE, BUSY} mstate_t;

    typedef struct packed {
        logic              we;
        logic              ir_wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } req_t;

    mstate_t           state, state_nxt;
    req_t              req;
    logic [ADDR_W-1:0] pc, pc_src, pc_nxt;
    logic [31:0]       ir, mdr, a_q, b_q, alu_out;
    logic [31:0]       rf [32];
    logic [31:0]       pc_ext, imm_sx, wr_data;
    logic [4:0]        wr_addr;
    logic              start, ack, pc_we, exc_take;

    assign start  = MemRead | MemWrite;
    assign ack    = (state == BUSY) & mem.mem_ack;
    assign pc_ext = 32'(pc);
    assign imm_sx = {{16{ir[15]}}, ir[15:0]};
    assign op     = ir[31:26];
    assign funct  = ir[5:0];

    assign mem.mem_req   = (state == BUSY);
    assign mem.mem_we    = req.we;
    assign mem.mem_addr  = req.addr;
    assign mem.mem_wdata = req.wdata;

    // Memory FSM; an ack seen while idle falls through untouched.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        unique case (state)
            IDLE: if (start) begin
                state_nxt = BUSY;
                stall     = 1'b1;
            end
            BUSY: if (mem.mem_ack) state_nxt = IDLE;
                  else             stall     = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            req <= '0;
        end else if (state == IDLE && start) begin
            req.we    <= MemWrite;
            req.ir_wr <= IRWrite;
            req.addr  <= IorD ? alu_out[ADDR_W-1:0] : pc;
            req.wdata <= b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ir  <= '0;
            mdr <= '0;
        end else if (ack && !req.we) begin
            mdr <= mem.mem_rdata;
            if (req.ir_wr) ir <= mem.mem_rdata;
        end
    end

    // Register file reads are sampled into A/B with the old contents when a
    // write to the same register lands on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q     <= '0;
            b_q     <= '0;
            alu_out <= '0;
        end else if (!stall) begin
            a_q     <= rf[ir[25:21]];
            b_q     <= rf[ir[20:16]];
            alu_out <= aluResult;
        end
    end

    always_comb begin
        unique case (RegDst)
            2'b01:   wr_addr = ir[15:11];
            2'b10:   wr_addr = 5'd31;
            default: wr_addr = ir[20:16];
        endcase
        unique case (MemToReg)
            2'b01:   wr_data = mdr;
            2'b10:   wr_data = pc_ext;
            default: wr_data = alu_out;
        endcase
    end

    // r0 is never written, so it reads back as its reset value of zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (RegWrite && !stall && wr_addr != 5'd0) begin
            rf[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        unique case (PCSource)
            2'b00:   pc_src = aluResult[ADDR_W-1:0];
            2'b01:   pc_src = alu_out[ADDR_W-1:0];
            2'b10:   pc_src = ADDR_W'({pc_ext[31:28], ir[25:0], 2'b00});
`ifdef DP_EPC_EN
            default: pc_src = EXC_VEC;
`else
            default: pc_src = '0;
`endif
        endcase
    end

`ifdef DP_EPC_EN
    assign exc_take = ExcTake & ~stall;
`else
    assign exc_take = 1'b0;
`endif

    assign pc_we  = ~stall & (PCWrite | (PCWriteCond & (zero ^ BranchNe)));
    assign pc_nxt = exc_take ? EXC_VEC : pc_src;

    always_ff @(posedge clk) begin
        if (!reset)                  pc <= RESET_PC;
        else if (exc_take || pc_we)  pc <= pc_nxt;
    end

`ifdef DP_EPC_EN
    always_ff @(posedge clk) begin
        if (!reset)        epc <= '0;
        else if (exc_take) epc <= pc - ADDR_W'(4);
    end
`endif

    always_comb begin
        unique case (ALUSrcA)
            2'b00:   aluParamData1 = pc_ext;
            2'b01:   aluParamData1 = a_q;
            2'b10:   aluParamData1 = ir;
            default: aluParamData1 = 32'd1;
        endcase
        unique case (ALUSrcB)
            2'b00:   aluParamData2 = b_q;
            2'b01:   aluParamData2 = 32'd4;
            2'b10:   aluParamData2 = imm_sx;
            default: aluParamData2 = {imm_sx[29:0], 2'b00};
        endcase
    end

endmodule
